// File: rtl/cmn_plru_way_alloc.sv
// Way allocator: picks an invalid way, else the PLRU-oldest eligible way,
// and drives the PLRU allocate strobe when the response is taken.
module cmn_plru_way_alloc #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [WIDTH-1:0]            req_lock_mask,
  input  logic [WIDTH-1:0][WIDTH-1:0] vv_matrix,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [WIDTH-1:0]            rsp_way,
  output logic [IDXW-1:0]             rsp_idx,
  output logic                        rsp_evict,
  output logic                        rsp_fail,
  output logic                        alloc_en,
  output logic [WIDTH-1:0]            v_alloc,
  input  logic                        inv_en,
  input  logic [WIDTH-1:0]            inv_mask,
  output logic [WIDTH-1:0]            way_valid
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             rsp_hs;
  logic             req_hs;
  logic [WIDTH-1:0] byp;
  logic [WIDTH-1:0] elig;
  logic [WIDTH-1:0] cand_x;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] vview;
  logic [WIDTH-1:0] free;
  logic [WIDTH-1:0] oldest;
  logic [WIDTH-1:0] sel_way;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_evict;
  logic             sel_fail;

  assign rsp_vld = (state_q == FULL);
  assign req_rdy = (state_q == EMPTY) || rsp_rdy;
  assign rsp_hs  = rsp_vld && rsp_rdy;
  assign req_hs  = req_vld && req_rdy;

  assign alloc_en = rst_n && rsp_hs && !rsp_fail;
  assign v_alloc  = alloc_en ? rsp_way : '0;

  // Way being allocated this cycle is about to become newest and valid
  always_comb begin
    byp    = (rsp_hs && req_hs) ? rsp_way : '0;
    elig   = ~req_lock_mask;
    cand_x = elig & ~byp;
    cand   = (|cand_x) ? cand_x : elig;
    vview  = way_valid | byp;
    free   = cand & ~vview;
  end

  always_comb begin
    oldest = '0;
    for (int i = 0; i < WIDTH; i++) begin
      oldest[i] = cand[i] &&
        !(|(vv_matrix[i] & cand & ~(WIDTH'(1) << i)));
    end
  end

  always_comb begin
    sel_way   = '0;
    sel_evict = 1'b0;
    sel_fail  = 1'b0;
    if (|free) begin
      sel_way = free & (~free + WIDTH'(1));
    end else if (|cand) begin
      sel_way   = oldest & (~oldest + WIDTH'(1));
      sel_evict = 1'b1;
    end else begin
      sel_fail = 1'b1;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_way[i]) sel_idx = sel_idx | IDXW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (req_hs) state_d = FULL;
      FULL:  if (rsp_hs && !req_hs) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_way   <= '0;
      rsp_idx   <= '0;
      rsp_evict <= 1'b0;
      rsp_fail  <= 1'b0;
    end else if (req_hs) begin
      rsp_way   <= sel_way;
      rsp_idx   <= sel_idx;
      rsp_evict <= sel_evict;
      rsp_fail  <= sel_fail;
    end
  end

  // Allocate is OR-ed in last so it wins over a same-cycle invalidate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      way_valid <= '0;
    end else begin
      way_valid <= (way_valid & ~(inv_en ? inv_mask : '0))
                 | v_alloc;
    end
  end

endmodule

// File: tb/tb_cmn_plru_way_alloc.sv
// Bench for cmn_plru_way_alloc with a 4-way tree PLRU model
// driving the age matrix; responses checked from a queue.
module tb_cmn_plru_way_alloc;

  localparam int W  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  way;
    logic [IW-1:0] idx;
    logic          evict;
    logic          fail;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                req_vld;
  logic                req_rdy;
  logic [W-1:0]        req_lock_mask;
  logic [W-1:0][W-1:0] vv_matrix;
  logic                rsp_vld;
  logic                rsp_rdy;
  logic [W-1:0]        rsp_way;
  logic [IW-1:0]       rsp_idx;
  logic                rsp_evict;
  logic                rsp_fail;
  logic                alloc_en;
  logic [W-1:0]        v_alloc;
  logic                inv_en;
  logic [W-1:0]        inv_mask;
  logic [W-1:0]        way_valid;

  exp_t q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   alloc_cnt   = 0;

  logic r_bit;
  logic n0;
  logic n1;

  cmn_plru_way_alloc #(.WIDTH(W), .IDXW(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_lock_mask (req_lock_mask),
    .vv_matrix     (vv_matrix),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_way       (rsp_way),
    .rsp_idx       (rsp_idx),
    .rsp_evict     (rsp_evict),
    .rsp_fail      (rsp_fail),
    .alloc_en      (alloc_en),
    .v_alloc       (v_alloc),
    .inv_en        (inv_en),
    .inv_mask      (inv_mask),
    .way_valid     (way_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree PLRU: r_bit=1 right half newer, n0=1 way1 newer, n1=1 way3 newer
  always @(posedge clk) begin
    if (!rst_n) begin
      r_bit <= 1'b0;
      n0    <= 1'b0;
      n1    <= 1'b0;
    end else if (alloc_en) begin
      case (v_alloc)
        4'b0001: begin r_bit <= 1'b0; n0 <= 1'b0; end
        4'b0010: begin r_bit <= 1'b0; n0 <= 1'b1; end
        4'b0100: begin r_bit <= 1'b1; n1 <= 1'b0; end
        4'b1000: begin r_bit <= 1'b1; n1 <= 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    vv_matrix = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (i != j) begin
          if ((i / 2) != (j / 2))
            vv_matrix[i][j] = (((i / 2) == 1) == r_bit);
          else
            vv_matrix[i][j] =
              (((i % 2) == 1) == (((i / 2) == 1) ? n1 : n0));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && alloc_en) alloc_cnt++;
    if (!rst_n || !rsp_vld) begin
      vectors++;
      if (alloc_en !== 1'b0) begin
        miscompares++;
        $display("FAIL alloc_idle got=%b want=0", alloc_en);
      end
    end
    if (rst_n && rsp_vld && rsp_rdy) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected got way=%b", rsp_way);
      end else begin
        mon_e = q.pop_front();
        if ({rsp_way, rsp_idx, rsp_evict, rsp_fail} !== mon_e) begin
          miscompares++;
          $display("FAIL rsp got way=%b idx=%0d ev=%b f=%b want way=%b idx=%0d ev=%b f=%b",
                   rsp_way, rsp_idx, rsp_evict, rsp_fail,
                   mon_e.way, mon_e.idx, mon_e.evict, mon_e.fail);
        end
        vectors++;
        if (alloc_en !== !mon_e.fail ||
            v_alloc !== (mon_e.fail ? 4'b0000 : mon_e.way)) begin
          miscompares++;
          $display("FAIL alloc got en=%b v=%b want en=%b v=%b",
                   alloc_en, v_alloc, !mon_e.fail,
                   mon_e.fail ? 4'b0000 : mon_e.way);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] way,
                              input logic [IW-1:0] idx,
                              input logic ev, input logic f);
    exp_t e;
    e.way   = way;
    e.idx   = idx;
    e.evict = ev;
    e.fail  = f;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] lock, input exp_t e,
                       output int waited);
    @(posedge clk); #1;
    req_vld       = 1'b1;
    req_lock_mask = lock;
    waited        = 0;
    @(negedge clk);
    while (!req_rdy && waited < 16) begin
      waited++;
      @(negedge clk);
    end
    vectors++;
    if (!req_rdy) begin
      miscompares++;
      $display("FAIL issue_timeout got req_rdy=%b want 1", req_rdy);
    end else begin
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_vld       = 1'b0;
    req_lock_mask = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 32) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got pending=%0d want 0", q.size());
    end
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp_vld got=%b want=0", rsp_vld);
    end
    vectors++;
    if (way_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_valid got=%b want=0000", way_valid);
    end
    vectors++;
    if (req_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_rdy got=%b want=1", req_rdy);
    end
    vectors++;
    if ({rsp_way, rsp_idx, rsp_evict, rsp_fail} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp got way=%b idx=%0d ev=%b f=%b want 0",
               rsp_way, rsp_idx, rsp_evict, rsp_fail);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    int w;
    int wsum;
    logic [W-1:0] way;
    a0   = alloc_cnt;
    wsum = 0;
    rsp_rdy = 1'b1;
    for (int k = 0; k < W; k++) begin
      way = 4'b0001 << k;
      issue(4'b0000, mk(way, IW'(k), 1'b0, 1'b0), w);
      wsum += w;
    end
    idle();
    drain();
    vectors++;
    if (wsum != 0) begin
      miscompares++;
      $display("FAIL b2b_stalls got=%0d want=0", wsum);
    end
    vectors++;
    if (way_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL b2b_valid got=%b want=1111", way_valid);
    end
    vectors++;
    if (alloc_cnt - a0 != 4) begin
      miscompares++;
      $display("FAIL b2b_allocs got=%0d want=4", alloc_cnt - a0);
    end
  endtask

  task automatic test_plru_victim();
    int w;
    issue(4'b0000, mk(4'b0001, 2'd0, 1'b1, 1'b0), w);
    issue(4'b0001, mk(4'b0010, 2'd1, 1'b1, 1'b0), w);
    idle();
    drain();
  endtask

  task automatic test_stall();
    int a0;
    @(posedge clk); #1;
    rsp_rdy       = 1'b0;
    req_vld       = 1'b1;
    req_lock_mask = '0;
    @(negedge clk);
    vectors++;
    if (req_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_first_rdy got=%b want=1", req_rdy);
    end
    q.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (req_rdy !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_req_rdy got=%b want=0", req_rdy);
      end
      vectors++;
      if (alloc_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_alloc got=%b want=0", alloc_en);
      end
      vectors++;
      if (rsp_vld !== 1'b1 || rsp_way !== 4'b0100 ||
          rsp_idx !== 2'd2 || rsp_evict !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold got v=%b way=%b idx=%0d ev=%b want 1 0100 2 1",
                 rsp_vld, rsp_way, rsp_idx, rsp_evict);
      end
    end
    a0 = alloc_cnt;
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_rdy got=%b want=1", req_rdy);
    end
    q.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    req_vld = 1'b0;
    vectors++;
    if (alloc_cnt - a0 != 1) begin
      miscompares++;
      $display("FAIL stall_one_pulse got=%0d want=1", alloc_cnt - a0);
    end
    drain();
  endtask

  task automatic test_invalidate();
    int w;
    @(posedge clk); #1;
    inv_en   = 1'b1;
    inv_mask = 4'b0100;
    @(posedge clk); #1;
    inv_en   = 1'b0;
    inv_mask = '0;
    @(negedge clk);
    vectors++;
    if (way_valid !== 4'b1011) begin
      miscompares++;
      $display("FAIL inv_valid got=%b want=1011", way_valid);
    end
    issue(4'b0000, mk(4'b0100, 2'd2, 1'b0, 1'b0), w);
    idle();
    drain();
  endtask

  task automatic test_all_locked();
    int w;
    issue(4'b1111, mk(4'b0000, 2'd0, 1'b0, 1'b1), w);
    idle();
    drain();
    vectors++;
    if (way_valid !== 4'b1111) begin
      miscompares++;
      $display("FAIL locked_valid got=%b want=1111", way_valid);
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    rsp_rdy       = 1'b0;
    req_vld       = 1'b1;
    req_lock_mask = '0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_rsp_vld got=%b want=1", rsp_vld);
    end
    @(posedge clk); #1;
    rst_n   = 1'b0;
    rsp_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (alloc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_alloc_in_rst got=%b want=0", alloc_en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rsp_drop got=%b want=0", rsp_vld);
    end
    vectors++;
    if (way_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_valid got=%b want=0000", way_valid);
    end
    vectors++;
    if (rsp_way !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_rsp_way got=%b want=0000", rsp_way);
    end
  endtask

  task automatic test_inv_alloc_same_way();
    int w;
    rsp_rdy = 1'b1;
    issue(4'b0000, mk(4'b0001, 2'd0, 1'b0, 1'b0), w);
    @(posedge clk); #1;
    req_vld  = 1'b0;
    inv_en   = 1'b1;
    inv_mask = 4'b0001;
    @(posedge clk); #1;
    inv_en   = 1'b0;
    inv_mask = '0;
    @(negedge clk);
    vectors++;
    if (way_valid !== 4'b0001) begin
      miscompares++;
      $display("FAIL inv_alloc_valid got=%b want=0001", way_valid);
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL inv_alloc_pending got=%0d want=0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    req_vld       = 1'b0;
    req_lock_mask = '0;
    rsp_rdy       = 1'b1;
    inv_en        = 1'b0;
    inv_mask      = '0;
    test_reset();
    test_back_to_back();
    test_plru_victim();
    test_stall();
    test_invalidate();
    test_all_locked();
    test_reset_midflight();
    test_inv_alloc_same_way();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
